// File: rtl/onehot_req_arbiter_pkg.sv
// Shared types and constants for the one-hot request arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int PTR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Index to one-hot decode; the only place a grant vector is built.
  function automatic req_vec_t idx2onehot(input ptr_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/onehot_req_arbiter_rr_pick.sv
// Combinational picker: rotate pending by ptr, find first set, unrotate.
// FIXED_PRIO_EN: scan highest-first; ptr is expected to be tied to 0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] pend_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] sel_o,
  output logic             found_o
);

  logic [N_REQ-1:0] rot;
  logic [PTR_W-1:0] off;

  // rot[i] is the bit i positions after ptr, wrapping modulo N_REQ.
  for (genvar i = 0; i < N_REQ; i++) begin : g_rot
    assign rot[i] = pend_i[PTR_W'(i) + ptr_i];
  end

  // Priority scan over the rotated vector; last assignment wins.
  always_comb begin
    found_o = 1'b0;
    off     = '0;
`ifdef FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (rot[i]) begin
        found_o = 1'b1;
        off     = PTR_W'(i);
      end
    end
`else
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        off     = PTR_W'(i);
      end
    end
`endif
  end

  // Undo the rotation; 3-bit add wraps naturally.
  assign sel_o = off + ptr_i;

endmodule

// File: rtl/onehot_req_arbiter.sv
// Request capture + round-robin arbiter producing a registered one-hot grant
// for the downstream 8-to-3 encoder. Grants are held until acknowledged.
// Build option: FIXED_PRIO_EN selects fixed priority (bit 7 highest) and
// removes the round-robin pointer.
module onehot_req_arbiter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_onehot_o,
  output logic             grant_vld_o,
  input  logic             grant_ack_i,
  output logic [N_REQ-1:0] pending_o,
  output logic             overflow_o
);

  state_e   state_q, state_d;
  req_vec_t pend_q, pend_d;
  req_vec_t grant_q, grant_d;
  logic     vld_q, vld_d;
  logic     ovf_q, ovf_d;
  req_vec_t retire;
  ptr_t     sel;
  logic     found;
  ptr_t     pick_ptr;

`ifdef FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  ptr_t rr_ptr_q, rr_ptr_d;
  ptr_t sel_q, sel_d;
  assign pick_ptr = rr_ptr_q;
`endif

  rr_pick u_pick (
    .pend_i  (pend_q),
    .ptr_i   (pick_ptr),
    .sel_o   (sel),
    .found_o (found)
  );

  // Next-state: grant FSM, retire of the selected bit, capture and overflow.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    vld_d    = vld_q;
    retire   = '0;
`ifndef FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = idx2onehot(sel);
          vld_d   = 1'b1;
          retire  = idx2onehot(sel);
          state_d = GRANT;
`ifndef FIXED_PRIO_EN
          sel_d   = sel;
`endif
        end
      end
      GRANT: begin
        if (grant_ack_i) begin
          grant_d  = '0;
          vld_d    = 1'b0;
          state_d  = IDLE;
`ifndef FIXED_PRIO_EN
          rr_ptr_d = sel_q + ptr_t'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request on the bit being retired keeps it pending (set wins).
    pend_d = (pend_q & ~retire) | req_i;
    ovf_d  = |(req_i & pend_q & ~retire);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      grant_q  <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifndef FIXED_PRIO_EN
      rr_ptr_q <= '0;
      sel_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      grant_q  <= grant_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
`ifndef FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
`endif
    end
  end

  // Grant must never be multi-hot and valid must track it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(grant_q));
      assert (vld_q == (|grant_q));
    end
  end

  assign grant_onehot_o = grant_q;
  assign grant_vld_o    = vld_q;
  assign pending_o      = pend_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Bench for onehot_req_arbiter: directed scenarios plus random traffic
// against a behavioural model of the arbitration rules.
module tb_onehot_req_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_i = '0;
  logic       grant_ack_i = 1'b0;
  logic [7:0] grant_onehot_o;
  logic       grant_vld_o;
  logic [7:0] pending_o;
  logic       overflow_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] m_pend;
  logic       m_vld;
  int         m_idx;
  int         m_ptr;
  logic       m_ovf;

  always #5 clk = ~clk;

  onehot_req_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .grant_onehot_o (grant_onehot_o),
    .grant_vld_o    (grant_vld_o),
    .grant_ack_i    (grant_ack_i),
    .pending_o      (pending_o),
    .overflow_o     (overflow_o)
  );

  function automatic logic [7:0] m_grant();
    logic [7:0] g;
    g = '0;
    if (m_vld) g[m_idx] = 1'b1;
    return g;
  endfunction

  // Selection rule from the arbitration description.
  function automatic int m_pick(input logic [7:0] p, input int ptr);
    int s;
    bit hit;
    s = 0;
    hit = 0;
`ifdef FIXED_PRIO_EN
    for (int k = 7; k >= 0; k--)
      if (!hit && p[k]) begin s = k; hit = 1; end
`else
    for (int j = 0; j < 8; j++)
      if (!hit && p[(ptr + j) % 8]) begin s = (ptr + j) % 8; hit = 1; end
`endif
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_i = 8'hFF;
    grant_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_i = '0;
    m_pend = '0; m_vld = 0; m_idx = 0; m_ptr = 0; m_ovf = 0;
  endtask

  // One clock with the given inputs; model advances alongside the DUT.
  task automatic cyc(input logic [7:0] req, input logic ack);
    logic [7:0] retire, n_pend;
    logic n_vld, n_ovf;
    int n_idx;
    req_i = req;
    grant_ack_i = ack;
    retire = '0;
    n_vld = m_vld;
    n_idx = m_idx;
    if (!m_vld && m_pend != 0) begin
      n_idx = m_pick(m_pend, m_ptr);
      n_vld = 1;
      retire[n_idx] = 1'b1;
    end else if (m_vld && ack) begin
      n_vld = 0;
      m_ptr = (m_idx + 1) % 8;
    end
    n_ovf  = |(req & m_pend & ~retire);
    n_pend = (m_pend & ~retire) | req;
    @(posedge clk);
    m_pend = n_pend; m_vld = n_vld; m_idx = n_idx; m_ovf = n_ovf;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (pending_o !== 8'h00 || grant_vld_o !== 1'b0 || grant_onehot_o !== 8'h00 || overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pend=%h vld=%b gnt=%h ovf=%b, want all 0", pending_o, grant_vld_o, grant_onehot_o, overflow_o);
    end
    cyc(8'h00, 0);
    vectors++;
    if (pending_o !== 8'h00 || grant_vld_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_post: pend=%h vld=%b, want 00/0", pending_o, grant_vld_o);
    end
    cyc(8'h01, 0);
    vectors++;
    if (pending_o !== 8'h01 || grant_vld_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_capture: pend=%h vld=%b, want 01/0", pending_o, grant_vld_o);
    end
    cyc(8'h00, 0);
    vectors++;
    if (grant_onehot_o !== 8'h01 || grant_vld_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_grant: gnt=%h vld=%b, want 01/1", grant_onehot_o, grant_vld_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    cyc(8'h10, 0);
    vectors++;
    if (pending_o !== 8'h10 || grant_vld_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_t1: pend=%h vld=%b, want 10/0", pending_o, grant_vld_o);
    end
    cyc(8'h00, 0);
    vectors++;
    if (grant_onehot_o !== 8'h10 || grant_vld_o !== 1'b1 || pending_o !== 8'h00) begin
      miscompares++;
      $display("FAIL single_t2: gnt=%h vld=%b pend=%h, want 10/1/00", grant_onehot_o, grant_vld_o, pending_o);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, 0);
      vectors++;
      if (grant_onehot_o !== 8'h10 || grant_vld_o !== 1'b1) begin
        miscompares++;
        $display("FAIL single_hold%0d: gnt=%h vld=%b, want 10/1", i, grant_onehot_o, grant_vld_o);
      end
    end
    cyc(8'h00, 1);
    vectors++;
    if (grant_onehot_o !== 8'h00 || grant_vld_o !== 1'b0 || pending_o !== 8'h00) begin
      miscompares++;
      $display("FAIL single_ack: gnt=%h vld=%b pend=%h, want 00/0/00", grant_onehot_o, grant_vld_o, pending_o);
    end
  endtask

`ifndef FIXED_PRIO_EN
  task automatic test_rr_wrap();
    logic [7:0] exp_g [3];
    exp_g[0] = 8'h01; exp_g[1] = 8'h80; exp_g[2] = 8'h01;
    do_reset();
    cyc(8'h81, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) cyc(8'h81, 0);
      cyc(8'h00, 0);
      vectors++;
      if (grant_onehot_o !== exp_g[i] || grant_vld_o !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_wrap%0d: gnt=%h vld=%b, want %h/1", i, grant_onehot_o, grant_vld_o, exp_g[i]);
      end
      cyc(8'h00, 1);
    end
  endtask
`else
  task automatic test_fixed();
    logic [7:0] exp_g [3];
    exp_g[0] = 8'h80; exp_g[1] = 8'h04; exp_g[2] = 8'h01;
    do_reset();
    cyc(8'h85, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 0);
      vectors++;
      if (grant_onehot_o !== exp_g[i] || grant_vld_o !== 1'b1) begin
        miscompares++;
        $display("FAIL fixed%0d: gnt=%h vld=%b, want %h/1", i, grant_onehot_o, grant_vld_o, exp_g[i]);
      end
      cyc(8'h00, 1);
    end
  endtask
`endif

  task automatic test_set_beats_retire();
    do_reset();
    cyc(8'h08, 0);
    cyc(8'h08, 0);
    vectors++;
    if (grant_onehot_o !== 8'h08 || pending_o !== 8'h08 || overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL sbr_select: gnt=%h pend=%h ovf=%b, want 08/08/0", grant_onehot_o, pending_o, overflow_o);
    end
    cyc(8'h00, 0);
    cyc(8'h00, 1);
    cyc(8'h00, 0);
    vectors++;
    if (grant_onehot_o !== 8'h08 || grant_vld_o !== 1'b1 || pending_o !== 8'h00) begin
      miscompares++;
      $display("FAIL sbr_regrant: gnt=%h vld=%b pend=%h, want 08/1/00", grant_onehot_o, grant_vld_o, pending_o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] hit;
    do_reset();
    cyc(8'h06, 0);
    cyc(8'h00, 0);
    hit = m_pend;
    vectors++;
    if (overflow_o !== 1'b0 || pending_o !== hit) begin
      miscompares++;
      $display("FAIL ovf_pre: ovf=%b pend=%h, want 0/%h", overflow_o, pending_o, hit);
    end
    cyc(hit, 0);
    vectors++;
    if (overflow_o !== 1'b1 || pending_o !== hit) begin
      miscompares++;
      $display("FAIL ovf_pulse: ovf=%b pend=%h, want 1/%h", overflow_o, pending_o, hit);
    end
    cyc(8'h00, 0);
    vectors++;
    if (overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf=%b, want 0", overflow_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cyc(r, 1'($urandom_range(0, 1)));
      vectors++;
      if (pending_o !== m_pend || grant_onehot_o !== m_grant() || grant_vld_o !== m_vld || overflow_o !== m_ovf) begin
        miscompares++;
        $display("FAIL random%0d: pend=%h gnt=%h vld=%b ovf=%b, want %h/%h/%b/%b", i, pending_o, grant_onehot_o,
                 grant_vld_o, overflow_o, m_pend, m_grant(), m_vld, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef FIXED_PRIO_EN
    test_rr_wrap();
`else
    test_fixed();
`endif
    test_set_beats_retire();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
